// File: rtl/cpu_branch_if.sv
// -----------------------------------------------------------------------------
// cpu_branch_if: memory-side bus of the cpu_branch core.
//   in        : read data from memory (instruction or load data)
//   mem_ready : transfer completes on a rising edge where it is 1
//   mem_cmd   : 00 none, 01 read, 10 write
//   mem_addr  : PC during fetch, data-address register otherwise
//   out       : datapath C register, doubles as the store write data
// master = CPU side, slave = memory side.
// -----------------------------------------------------------------------------
interface cpu_branch_if #(
  parameter int ADDR_W = 9
) ();
  logic [15:0]       in;
  logic              mem_ready;
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       out;

  modport master (input in, input mem_ready, output mem_cmd, output mem_addr, output out);
  modport slave  (output in, output mem_ready, input mem_cmd, input mem_addr, input out);
endinterface

// File: rtl/cpu_branch.sv
// -----------------------------------------------------------------------------
// cpu_branch: multicycle 16-bit CPU core with conditional branches and calls.
// FSM, PC, instruction register and data-address register, driving an
// 8x16 register file / shifter / ALU / C register / N-V-Z status datapath.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low
//   bus    : memory interface (cpu_branch_if.master)
//   N,V,Z  : status flags, loaded only by CMP
//   halted : high while the core sits in HALT (left only by reset)
// -----------------------------------------------------------------------------
module cpu_branch #(
  parameter int                ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  cpu_branch_if.master bus,
  output logic         N,
  output logic         V,
  output logic         Z,
  output logic         halted
);
  localparam logic [1:0] MNONE = 2'b00, MREAD = 2'b01, MWRITE = 2'b10;

  typedef enum logic [4:0] {
    S_RST, S_FETCH, S_DECODE, S_WIMM, S_GETA, S_GETB, S_EXEC, S_WB, S_STATUS,
    S_ADDR, S_MEMRD, S_PASS, S_MEMWR, S_BR, S_LINK, S_JUMP, S_HALT
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] pc, da;
  logic [15:0]       ir;
  logic [1:0]        mem_cmd;

  // Instruction fields
  logic [2:0]  opcode, rn, rd, rm;
  logic [1:0]  op, shift;
  logic [15:0] sximm5, sximm8;
  logic        is_str, is_mem;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign shift  = ir[4:3];
  assign rm     = ir[2:0];
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign is_str = (opcode == 3'b100);
  assign is_mem = is_str || (opcode == 3'b011);

  // Datapath storage
  logic [15:0] rf [8];
  logic [15:0] a_reg, b_reg, c_reg;
  logic [2:0]  rnum, wnum;
  logic        rf_we, alu_v, taken;
  logic [1:0]  vsel, sh_sel, alu_op;
  logic [15:0] wdata, b_sh, a_in, b_in, alu_out;

  assign bus.mem_cmd  = mem_cmd;
  // Before the first fetch DA is still 0, so the reset state also shows the PC.
  assign bus.mem_addr = (state == S_FETCH || state == S_RST) ? pc : da;
  assign bus.out      = c_reg;

  // Next-state logic
  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE:
        case ({opcode, op})
          5'b110_10:                                    state_d = S_WIMM;
          5'b110_00, 5'b101_11, 5'b101_00, 5'b101_10,
          5'b101_01, 5'b010_00, 5'b010_10:              state_d = S_GETB;
          5'b011_00, 5'b100_00:                         state_d = S_GETA;
          5'b001_00:                                    state_d = S_BR;
          5'b010_11:                                    state_d = S_LINK;
          default:                                      state_d = S_HALT;
        endcase
      // STR (second visit) and BX/BLX move Rd into C; ADD/AND/CMP still need A.
      S_GETB:   if (is_str || opcode == 3'b010)         state_d = S_PASS;
                else if (opcode == 3'b101 && op != 2'b11) state_d = S_GETA;
                else                                     state_d = S_EXEC;
      S_GETA:   if (is_mem)                              state_d = S_ADDR;
                else if (op == 2'b01)                    state_d = S_STATUS;
                else                                     state_d = S_EXEC;
      S_ADDR:   state_d = is_str ? S_GETB : S_MEMRD;
      S_EXEC:   state_d = S_WB;
      S_PASS:   state_d = is_str ? S_MEMWR : S_JUMP;
      S_MEMRD, S_MEMWR: if (bus.mem_ready) state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Branch condition from the current status flags
  always_comb begin
    case (rn)
      3'b000:  taken = 1'b1;
      3'b001:  taken = Z;
      3'b010:  taken = !Z;
      3'b011:  taken = N ^ V;
      3'b100:  taken = (N ^ V) | Z;
      default: taken = 1'b0;
    endcase
  end

  // Control FSM; mem_cmd and halted are registered from the next state so they
  // switch on the same edge as the state itself.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_RST;
      pc      <= RESET_PC;
      ir      <= '0;
      da      <= '0;
      mem_cmd <= MNONE;
      halted  <= 1'b0;
    end else begin
      state   <= state_d;
      halted  <= (state_d == S_HALT);
      case (state_d)
        S_FETCH, S_MEMRD: mem_cmd <= MREAD;
        S_MEMWR:          mem_cmd <= MWRITE;
        default:          mem_cmd <= MNONE;
      endcase
      case (state)
        S_FETCH: if (bus.mem_ready) begin
          ir <= bus.in;
          pc <= pc + ADDR_W'(1);
        end
        S_BR:    if (taken) pc <= pc + sximm8[ADDR_W-1:0];
        S_LINK:  pc <= pc + sximm8[ADDR_W-1:0];
        S_JUMP:  pc <= c_reg[ADDR_W-1:0];
        S_ADDR:  da <= alu_out[ADDR_W-1:0];
        default: ;
      endcase
    end
  end

  // Datapath control
  always_comb begin
    rnum   = (state == S_GETA) ? rn : ((is_str || opcode == 3'b010) ? rd : rm);
    sh_sel = (state == S_PASS) ? 2'b00 : shift;
    case (sh_sel)
      2'b01:   b_sh = {b_reg[14:0], 1'b0};
      2'b10:   b_sh = {1'b0, b_reg[15:1]};
      2'b11:   b_sh = {b_reg[15], b_reg[15:1]};
      default: b_sh = b_reg;
    endcase
    // MOV/PASS add the B operand to zero; address generation uses sximm5.
    a_in   = (state == S_PASS || opcode == 3'b110) ? 16'h0000 : a_reg;
    b_in   = (state == S_ADDR) ? sximm5 : b_sh;
    alu_op = (state == S_ADDR || state == S_PASS || opcode == 3'b110) ? 2'b00 : op;
    case (alu_op)
      2'b00:   alu_out = a_in + b_in;
      2'b01:   alu_out = a_in - b_in;
      2'b10:   alu_out = a_in & b_in;
      default: alu_out = ~b_in;
    endcase
    alu_v = (alu_op == 2'b01) && (a_in[15] != b_in[15]) && (alu_out[15] != a_in[15]);

    rf_we = 1'b0;
    wnum  = rd;
    vsel  = 2'b11;
    case (state)
      S_WIMM:  begin rf_we = 1'b1; wnum = rn; vsel = 2'b01; end
      S_WB:    rf_we = 1'b1;
      S_MEMRD: begin rf_we = bus.mem_ready; vsel = 2'b00; end
      S_LINK:  begin rf_we = 1'b1; wnum = 3'd7; vsel = 2'b10; end
      S_JUMP:  begin rf_we = (op == 2'b10); wnum = 3'd7; vsel = 2'b10; end
      default: ;
    endcase
    case (vsel)
      2'b00:   wdata = bus.in;
      2'b01:   wdata = sximm8;
      2'b10:   wdata = 16'(pc);
      default: wdata = c_reg;
    endcase
  end

  // NOTE: the register file and operand registers carry no reset; software
  // writes a register before reading it, and leaving them unreset keeps the
  // storage a plain memory array.
  always_ff @(posedge clk) begin
    if (rf_we) rf[wnum] <= wdata;
    if (state == S_GETA) a_reg <= rf[rnum];
    if (state == S_GETB) b_reg <= rf[rnum];
    if (state == S_EXEC || state == S_PASS) c_reg <= alu_out;
    if (state == S_STATUS) begin
      N <= alu_out[15];
      V <= alu_v;
      Z <= (alu_out == 16'h0000);
    end
  end
endmodule
